hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, stall cycles a load imposes on a dependent instruction.
REQ-003 SHALL have parameter MD_LAT, default 32, stall cycles a mult/div imposes on a dependent instruction and on a following mult/div.
REQ-004 SHALL have parameter CNT_W, default 6, counter width; must satisfy 2^CNT_W > max(LOAD_LAT, MD_LAT).
REQ-005 SHALL have port clock, input, 1, the single clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, the decode stage holds an instruction.
REQ-008 SHALL have ports src_a and src_b, input, REG_ADDR_W each, source register addresses.
REQ-009 SHALL have ports src_a_en and src_b_en, input, 1 each, the matching source is read.
REQ-010 SHALL have port dst, input, REG_ADDR_W, destination register address.
REQ-011 SHALL have port dst_en, input, 1, the instruction writes dst.
REQ-012 SHALL have port cls, input, 2, instruction class: 00 single-cycle ALU, 01 load, 10 mult/div, 11 treated as 00.
REQ-013 SHALL have port flush, input, 1, squash all in-flight producers.
REQ-014 SHALL have port stall, output, 1, hold the decode stage this cycle.
REQ-015 SHALL have port md_busy, output, 1, the mult/div unit is occupied.
REQ-016 SHALL have port stall_cnt, output, 16, saturating count of stalled cycles.

Function
REQ-017 SHALL keep one CNT_W-bit countdown per register address 1..2^REG_ADDR_W-1; register 0 has no counter and never causes a stall.
REQ-018 SHALL hold one CNT_W-bit mult/div occupancy counter md_cnt; md_busy = (md_cnt != 0).
REQ-019 SHALL drive stall combinationally = in_valid & ~flush & (RAW | WAW | STRUCT).
REQ-020 SHALL set RAW when an enabled source is nonzero and its counter is nonzero.
REQ-021 SHALL set WAW when dst_en, dst is nonzero, and counter[dst] exceeds the new instruction's latency (LOAD_LAT, MD_LAT, or 0).
REQ-022 SHALL set STRUCT when cls = 10 and md_cnt != 0.
REQ-023 SHALL define issue = in_valid & ~stall & ~flush.
REQ-024 On issue with dst_en, dst nonzero, and cls 01, SHALL load counter[dst] with LOAD_LAT at the next edge.
REQ-025 On issue with dst_en, dst nonzero, and cls 10, SHALL load counter[dst] with MD_LAT at the next edge.
REQ-026 On issue with cls 10, SHALL load md_cnt with MD_LAT at the next edge, regardless of dst_en.
REQ-027 On issue with dst_en, dst nonzero, and cls 00/11, SHALL clear counter[dst] at the next edge.
REQ-028 Every other nonzero counter SHALL decrement by 1 per cycle and hold at 0; an issue write to the same counter overrides the decrement.
REQ-029 A dependent instruction decoded in the cycle after a load issues SHALL stall exactly LOAD_LAT cycles; with LOAD_LAT = 0, loads never stall.
REQ-030 On flush, SHALL clear all register counters and md_cnt at the next edge, perform no issue, and deassert stall in that cycle.
REQ-031 SHALL increment stall_cnt on each cycle with stall = 1 and saturate at 16'hFFFF.
REQ-032 SHALL introduce zero added latency: a hazard-free instruction issues in the same cycle it is presented.

Reset
REQ-033 On reset_n low, SHALL asynchronously clear all register counters, md_cnt, and stall_cnt; stall and md_busy then follow from the cleared state (0 while reset is held).
REQ-034 Reset deasserted mid-countdown SHALL leave no residual stall; the first cycle after release behaves as empty.

Verification
REQ-035 SHALL cover: lw r5 issued, then add reading r5 (LOAD_LAT = 1) -> stall = 1 for 1 cycle, issue on the next; stall_cnt = 1.
REQ-036 SHALL cover: lw r0, then a reader of r0 -> stall = 0 in every cycle.
REQ-037 SHALL cover: mul to r3 (MD_LAT = 32), then a reader of r3 -> 32 stall cycles and md_busy high for 32 cycles; a second mul during that time -> stall until md_cnt = 0.
REQ-038 SHALL cover: mul to r4, then lw to r4 -> WAW stall until counter[r4] <= 1, then issue.
REQ-039 SHALL cover: lw r7 followed by flush, then a reader of r7 -> stall = 0.
REQ-040 SHALL cover: reset_n pulsed low during a mul countdown -> md_busy = 0 and stall_cnt = 0 immediately, and no stall after release.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard interface.
// Carries the instruction presented by the decode stage (valid, sources,
// destination, class, flush) and returns the hazard verdict (stall),
// mult/div occupancy (md_busy) and the saturating stalled-cycle count.
//   master : decode stage; drives the instruction and reads the verdict
//   slave  : hazard scoreboard; reads the instruction and drives the verdict
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic [REG_ADDR_W-1:0] src_a;
  logic [REG_ADDR_W-1:0] src_b;
  logic                  src_a_en;
  logic                  src_b_en;
  logic [REG_ADDR_W-1:0] dst;
  logic                  dst_en;
  logic [1:0]            cls;
  logic                  flush;
  logic                  stall;
  logic                  md_busy;
  logic [15:0]           stall_cnt;

  modport master (
    output in_valid, src_a, src_b, src_a_en, src_b_en, dst, dst_en, cls, flush,
    input  stall, md_busy, stall_cnt
  );

  modport slave (
    input  in_valid, src_a, src_b, src_a_en, src_b_en, dst, dst_en, cls, flush,
    output stall, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for an in-order decode stage.
// Tracks per-register countdowns of outstanding producer latency and a
// mult/div occupancy counter, and stalls decode on RAW, WAW and mult/div
// structural hazards. A hazard-free instruction issues in the cycle it is
// presented.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   dec     : hazard_scoreboard_if.slave (instruction in, stall/md_busy/stall_cnt out)
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MD_LAT     = 32,
  parameter int CNT_W      = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  hazard_scoreboard_if.slave  dec
);

  localparam int NREG = 1 << REG_ADDR_W;

  localparam logic [CNT_W-1:0] LOAD_LAT_C = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] MD_LAT_C   = CNT_W'(MD_LAT);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_MD   = 2'b10;

  // Entry 0 is never written, so r0 reads as "no outstanding producer".
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic [CNT_W-1:0] new_lat;
  logic             raw_a, raw_b, waw, strct;
  logic             stall, issue;
  logic             wr_dst;

  // Hazard detection (combinational, zero added latency)
  always_comb begin
    new_lat = '0;
    if (dec.cls == CLS_LOAD)    new_lat = LOAD_LAT_C;
    else if (dec.cls == CLS_MD) new_lat = MD_LAT_C;

    raw_a = dec.src_a_en && (dec.src_a != '0) && (cnt_q[dec.src_a] != '0);
    raw_b = dec.src_b_en && (dec.src_b != '0) && (cnt_q[dec.src_b] != '0);
    // A new writer may not finish before an older writer of the same register.
    waw   = dec.dst_en && (dec.dst != '0) && (cnt_q[dec.dst] > new_lat);
    strct = (dec.cls == CLS_MD) && (md_cnt_q != '0);

    stall  = dec.in_valid && !dec.flush && (raw_a || raw_b || waw || strct);
    issue  = dec.in_valid && !stall && !dec.flush;
    wr_dst = issue && dec.dst_en && (dec.dst != '0);
  end

  // Next-state for countdowns and statistics
  always_comb begin
    cnt_d       = cnt_q;
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (dec.flush) begin
      cnt_d    = '{default: '0};
      md_cnt_d = '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_dst && (dec.dst == REG_ADDR_W'(r))) begin
          // cls 11 falls into the single-cycle case together with 00.
          cnt_d[r] = new_lat;
        end else if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - ONE_C;
        end
      end

      if (issue && (dec.cls == CLS_MD)) begin
        md_cnt_d = MD_LAT_C;
      end else if (md_cnt_q != '0) begin
        md_cnt_d = md_cnt_q - ONE_C;
      end
    end

    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '{default: '0};
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dec.stall     = stall;
  assign dec.md_busy   = (md_cnt_q != '0);
  assign dec.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic clock;
  logic reset_n;
  int   vec_cnt;
  int   err_cnt;
  int   n;
  int   nb;

  hazard_scoreboard_if #(.REG_ADDR_W(5)) ifc ();

  hazard_scoreboard #(
    .REG_ADDR_W(5),
    .LOAD_LAT  (1),
    .MD_LAT    (32),
    .CNT_W     (6)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .dec    (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_instr(input logic v, input logic [4:0] sa, input logic sae,
                           input logic [4:0] sb, input logic sbe,
                           input logic [4:0] d, input logic de, input logic [1:0] c);
    ifc.in_valid = v;
    ifc.src_a    = sa;
    ifc.src_a_en = sae;
    ifc.src_b    = sb;
    ifc.src_b_en = sbe;
    ifc.dst      = d;
    ifc.dst_en   = de;
    ifc.cls      = c;
    ifc.flush    = 1'b0;
  endtask

  task automatic idle();
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);
  endtask

  // Leaves time at 1 unit after a rising edge with the bench out of reset.
  task automatic do_reset();
    idle();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Counts consecutive stalled cycles (and md_busy cycles among them);
  // entered and left at 2 units after an edge.
  task automatic count_stalls();
    n  = 0;
    nb = 0;
    while (ifc.stall === 1'b1 && n < 100) begin
      n++;
      if (ifc.md_busy === 1'b1) nb++;
      @(posedge clock);
      #2;
    end
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    set_instr(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 2'b10);
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall: got %b expected 0", ifc.stall); end
    vec_cnt++;
    if (ifc.md_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_md_busy: got %b expected 0", ifc.md_busy); end
    vec_cnt++;
    if (ifc.stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL reset_stall_cnt: got %0d expected 0", ifc.stall_cnt); end
    idle();
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01);   // lw r5
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL lu_lw_issue: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 2'b00);   // add r6, r5, r2
    #1;
    count_stalls();
    vec_cnt++;
    if (n !== 1) begin err_cnt++; $display("FAIL lu_stall_cycles: got %0d expected 1", n); end
    vec_cnt++;
    if (ifc.stall_cnt !== 16'd1) begin err_cnt++; $display("FAIL lu_stall_cnt: got %0d expected 1", ifc.stall_cnt); end
    next_cycle();
    idle();
    #1;
    vec_cnt++;
    if (ifc.stall_cnt !== 16'd1) begin err_cnt++; $display("FAIL lu_stall_cnt_hold: got %0d expected 1", ifc.stall_cnt); end
  endtask

  task automatic test_r0();
    do_reset();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01);   // lw r0
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL r0_lw: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'b01);   // lw r0, reads r0
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL r0_reader1: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 2'b00);
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL r0_reader2: got %b expected 0", ifc.stall); end
    vec_cnt++;
    if (ifc.stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL r0_stall_cnt: got %0d expected 0", ifc.stall_cnt); end
    next_cycle();
    idle();
  endtask

  task automatic test_mul();
    do_reset();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'b10);   // mul r3
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL mul_issue: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);   // reader of r3
    #1;
    count_stalls();
    vec_cnt++;
    if (n !== 32) begin err_cnt++; $display("FAIL mul_raw_cycles: got %0d expected 32", n); end
    vec_cnt++;
    if (nb !== 32) begin err_cnt++; $display("FAIL mul_busy_cycles: got %0d expected 32", nb); end
    vec_cnt++;
    if (ifc.md_busy !== 1'b0) begin err_cnt++; $display("FAIL mul_busy_end: got %b expected 0", ifc.md_busy); end
    vec_cnt++;
    if (ifc.stall_cnt !== 16'd32) begin err_cnt++; $display("FAIL mul_stall_cnt: got %0d expected 32", ifc.stall_cnt); end
    next_cycle();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'b10);   // mul r3
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL mul2_issue: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'b10);   // mul r6, structural
    #1;
    count_stalls();
    vec_cnt++;
    if (n !== 32) begin err_cnt++; $display("FAIL mul_struct_cycles: got %0d expected 32", n); end
    vec_cnt++;
    if (ifc.stall_cnt !== 16'd64) begin err_cnt++; $display("FAIL mul_struct_cnt: got %0d expected 64", ifc.stall_cnt); end
    next_cycle();
    idle();
    #1;
    vec_cnt++;
    if (ifc.md_busy !== 1'b1) begin err_cnt++; $display("FAIL mul_struct_busy: got %b expected 1", ifc.md_busy); end
  endtask

  task automatic test_waw();
    do_reset();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'b10);   // mul r4
    #1;
    next_cycle();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'b01);   // lw r4
    #1;
    count_stalls();
    vec_cnt++;
    if (n !== 31) begin err_cnt++; $display("FAIL waw_cycles: got %0d expected 31", n); end
    next_cycle();
    set_instr(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);   // reader of r4
    #1;
    count_stalls();
    vec_cnt++;
    if (n !== 1) begin err_cnt++; $display("FAIL waw_then_raw: got %0d expected 1", n); end
    next_cycle();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b01);   // lw r7
    #1;
    next_cycle();
    set_instr(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);
    ifc.flush = 1'b1;
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL flush_cycle_stall: got %b expected 0", ifc.stall); end
    next_cycle();
    ifc.flush = 1'b0;
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL flush_lw_reader: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b10);   // mul r7
    #1;
    next_cycle();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'b10);   // mul r9, squashed
    ifc.flush = 1'b1;
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL flush_mul_stall: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 2'b00);
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL flush_mul_reader: got %b expected 0", ifc.stall); end
    vec_cnt++;
    if (ifc.md_busy !== 1'b0) begin err_cnt++; $display("FAIL flush_md_busy: got %b expected 0", ifc.md_busy); end
    vec_cnt++;
    if (ifc.stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL flush_stall_cnt: got %0d expected 0", ifc.stall_cnt); end
    next_cycle();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'b10);   // mul r3
    #1;
    next_cycle();
    set_instr(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);
    repeat (5) next_cycle();
    #1;
    vec_cnt++;
    if (ifc.stall_cnt !== 16'd5) begin err_cnt++; $display("FAIL rmid_pre_cnt: got %0d expected 5", ifc.stall_cnt); end
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if (ifc.md_busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_md_busy: got %b expected 0", ifc.md_busy); end
    vec_cnt++;
    if (ifc.stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL rmid_stall_cnt: got %0d expected 0", ifc.stall_cnt); end
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL rmid_stall_in_reset: got %b expected 0", ifc.stall); end
    next_cycle();
    reset_n = 1'b1;
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL rmid_stall_after: got %b expected 0", ifc.stall); end
    next_cycle();
    idle();
    #1;
    vec_cnt++;
    if (ifc.stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL rmid_cnt_after: got %0d expected 0", ifc.stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_instr(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 2'b00);   // add r1
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL b2b_add1: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 2'b00);   // add r2, r1, r1
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL b2b_add2: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 2'b11);   // cls 11 as ALU
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL b2b_cls11: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 2'b01);  // lw r10
    #1;
    vec_cnt++;
    if (ifc.stall !== 1'b0) begin err_cnt++; $display("FAIL b2b_lw: got %b expected 0", ifc.stall); end
    next_cycle();
    set_instr(1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 5'd11, 1'b1, 2'b00); // reads r10 on port b
    #1;
    count_stalls();
    vec_cnt++;
    if (n !== 1) begin err_cnt++; $display("FAIL b2b_load_use_b: got %0d expected 1", n); end
    next_cycle();
    idle();
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset_n = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_r0();
    test_mul();
    test_waw();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
